act_seq_ctrl: RTL and testbench
===============================

# act_seq_ctrl

Job sequencer for the packed-int8 activation stage. It accepts a job descriptor, streams 64-bit accumulator rows (8 lanes × 8 bit) from the accumulator buffer through the combinational activation unit, and writes each activated row to the output buffer over a valid/ready channel. It sits between the systolic-array accumulator buffer and the output/writeback buffer, and owns the activation unit's mode and operand inputs.

## Interface
- ADDR_W, 8, width of source/destination row addresses and row count
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  controller can accept a job
- cfg_mode  in  3  activation mode for the job (0 ReLU, 1 step, 2 identity, 3 leaky ReLU)
- cfg_rows  in  ADDR_W  number of rows in the job; 0 = empty job
- cfg_src_base  in  ADDR_W  first accumulator row address
- cfg_dst_base  in  ADDR_W  first output row address
- acc_rd_en  out  1  accumulator buffer read strobe
- acc_rd_addr  out  ADDR_W  accumulator read address
- acc_rd_data  in  64  read data, valid exactly 1 cycle after acc_rd_en
- act_mode  out  3  mode input to the activation unit
- act_sum  out  64  operand input to the activation unit
- act_result  in  64  combinational result from the activation unit
- out_valid  out  1  output row valid
- out_ready  in  1  output buffer accepts the row
- out_addr  out  ADDR_W  output row address
- out_data  out  64  activated row
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  qualifies done: job rejected (illegal mode)

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, latch mode, rows, src, dst; zero the row counter.
  - If cfg_mode>3: go to DONE with err=1. No reads, no writes.
  - Else if cfg_rows==0: go to DONE with err=0.
  - Else: go to RD.
- RD: acc_rd_en=1 for exactly this cycle, acc_rd_addr=src+count; next state CAP.
- CAP: act_sum=acc_rd_data (passthrough). On the clock edge, out_data<=act_result and out_addr<=dst+count. Next state WR.
- WR: out_valid=1. On out_ready, increment count. If count+1==rows, go to DONE; otherwise go to RD. If out_ready is low, hold WR; out_data and out_addr stay stable.
- DONE: done=1 for one cycle, err as latched; next state IDLE.
- act_mode = latched mode from acceptance until return to IDLE; 0 in IDLE.
- act_sum = 0 outside CAP.
- Address arithmetic is modulo 2^ADDR_W: src+count and dst+count wrap silently.
- cfg_ready=0 in every state except IDLE. A descriptor presented during DONE is not accepted until the following IDLE cycle.
- busy=1 in RD, CAP, WR and DONE.
- err=0 whenever done=0.
- Reset, including mid-job: state returns to IDLE immediately and any pending write is dropped without completion.
  - All outputs are 0 in reset, except cfg_ready, which is 1 once rst deasserts (IDLE).

## Timing
- Handshake in cycle T.
  - RD of row k at T+1+3k, CAP at T+2+3k, first WR cycle at T+3+3k.
  - These hold with out_ready always high; each stalled WR cycle adds 1 to all later events.
- N-row job, no stalls: done at T+1+3N; cfg_ready again at T+2+3N.
- Empty or illegal job: done at T+1; cfg_ready at T+2.
- acc_rd_data is sampled only in CAP, i.e. one cycle after acc_rd_en.
- The act_sum→act_result path is combinational within CAP and is registered at the end of CAP.

## Test plan
- Bench stub: act_result = ~act_sum.
- Identity-stub job: mode=2, rows=2, src=0x10, dst=0x40; rows hold 0x0102030405060708 and 0x8000FF7F00010203; out_ready=1.
  - Writes go to 0x40 with 0xFEFDFCFBFAF9F8F7, then to 0x41 with 0x7FFF0080FFFEFDFC.
  - act_mode=2 during CAP; done at T+7; err=0.
- Backpressure: same job with out_ready low for 4 cycles on row 0.
  - out_valid, out_addr and out_data stay stable throughout; no second acc_rd_en until the handshake completes.
  - done at T+11.
- Boundary jobs:
  - rows=0: done at T+1, err=0, no acc_rd_en and no out_valid.
  - mode=5, rows=3: done at T+1, err=1, no accesses.
- Wrap: src=0xFE, dst=0xFF, rows=3.
  - Reads at 0xFE, 0xFF, 0x00; writes at 0xFF, 0x00, 0x01.
- Reset mid-job: assert rst during WR of row 1 of a 4-row job.
  - Immediately: out_valid=0, busy=0, done=0, act_mode=0.
  - After rst deasserts: cfg_ready=1.
  - A new 1-row job completes normally with done at T+4.
- Back-to-back: cfg_valid held high with two descriptors.
  - The second is accepted in the IDLE cycle after the first done, never during DONE.

Source files
------------

// File: rtl/act_seq_ctrl.sv
// Job sequencer for the packed-int8 activation stage: reads accumulator rows, drives the
// combinational activation unit and writes each activated row over a valid/ready channel.
module act_seq_ctrl #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_mode,
   input  logic [ADDR_W-1:0] cfg_rows,
   input  logic [ADDR_W-1:0] cfg_src_base,
   input  logic [ADDR_W-1:0] cfg_dst_base,
   output logic              acc_rd_en,
   output logic [ADDR_W-1:0] acc_rd_addr,
   input  logic [63:0]       acc_rd_data,
   output logic [2:0]        act_mode,
   output logic [63:0]       act_sum,
   input  logic [63:0]       act_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [63:0]       out_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

   state_e            state_q, state_d;
   logic [2:0]        mode_q;
   logic [ADDR_W-1:0] rows_q, src_q, dst_q, count_q, out_addr_q;
   logic [63:0]       out_data_q;
   logic              err_q;
   logic              accept;

   assign accept = cfg_valid && (state_q == StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         mode_q     <= '0;
         rows_q     <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         count_q    <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mode_q  <= cfg_mode;
            rows_q  <= cfg_rows;
            src_q   <= cfg_src_base;
            dst_q   <= cfg_dst_base;
            count_q <= '0;
            err_q   <= (cfg_mode > 3'd3);
         end
         // Activation result is captured at the end of CAP and held through any WR stall.
         if (state_q == StCap) begin
            out_data_q <= act_result;
            out_addr_q <= dst_q + count_q;
         end
         if ((state_q == StWr) && out_ready) begin
            count_q <= count_q + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cfg_ready   = 1'b0;
      acc_rd_en   = 1'b0;
      acc_rd_addr = '0;
      act_mode    = mode_q;
      act_sum     = '0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      err         = 1'b0;
      unique case (state_q)
         StIdle: begin
            cfg_ready = !rst;
            busy      = 1'b0;
            act_mode  = '0;
            if (cfg_valid) begin
               if (cfg_mode > 3'd3) begin
                  state_d = StDone;
               end else if (cfg_rows == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            acc_rd_en   = 1'b1;
            acc_rd_addr = src_q + count_q;
            state_d     = StCap;
         end
         StCap: begin
            act_sum = acc_rd_data;
            state_d = StWr;
         end
         StWr: begin
            out_valid = 1'b1;
            if (out_ready) begin
               // rows_q is nonzero whenever WR is reachable.
               state_d = (count_q == rows_q - ADDR_W'(1)) ? StDone : StRd;
            end
         end
         StDone: begin
            done    = 1'b1;
            err     = err_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign out_addr = out_addr_q;
   assign out_data = out_data_q;

endmodule

// File: tb/tb_act_seq_ctrl.sv
// Self-checking bench for act_seq_ctrl: directed and random jobs checked against a
// job-level reference model (expected read/write lists and completion cycle).
module tb_act_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid, cfg_ready;
   logic [2:0]  cfg_mode;
   logic [7:0]  cfg_rows, cfg_src_base, cfg_dst_base;
   logic        acc_rd_en;
   logic [7:0]  acc_rd_addr;
   logic [63:0] acc_rd_data;
   logic [2:0]  act_mode;
   logic [63:0] act_sum, act_result;
   logic        out_valid, out_ready;
   logic [7:0]  out_addr;
   logic [63:0] out_data;
   logic        busy, done, err;

   logic [63:0] mem [256];
   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_done = 0;

   always #5 clk = ~clk;

   assign act_result = ~act_sum;

   always @(posedge clk) if (acc_rd_en) acc_rd_data <= mem[acc_rd_addr];

   act_seq_ctrl #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
      .cfg_rows(cfg_rows), .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
      .act_mode(act_mode), .act_sum(act_sum), .act_result(act_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // One job: model builds expected reads/writes, monitor compares cycle by cycle.
   task automatic run_job(input logic [2:0] m, input logic [7:0] r, input logic [7:0] s,
                          input logic [7:0] d, input int stall_pct, input int stall0,
                          input int abort_row, input bit hold, input bit chain);
      logic [7:0]  exp_rd[$];
      logic [7:0]  exp_wa[$];
      logic [63:0] exp_wd[$];
      logic [7:0]  prev_addr;
      bit          legal, prev_rd, got_done;
      int          t, stalls, row, forced, extra_rd, extra_wr, budget;
      legal = (m <= 3'd3);
      prev_rd = 1'b0; prev_addr = '0; got_done = 1'b0;
      stalls = 0; row = 0; forced = 0; extra_rd = 0; extra_wr = 0;
      if (legal) begin
         for (int k = 0; k < int'(r); k++) begin
            exp_rd.push_back(s + 8'(k));
            exp_wa.push_back(d + 8'(k));
            exp_wd.push_back(~mem[s + 8'(k)]);
         end
      end
      t = -1;
      for (int i = 0; i < 8 && t < 0; i++) begin
         tick();
         cfg_valid = 1'b1; cfg_mode = m; cfg_rows = r; cfg_src_base = s; cfg_dst_base = d;
         if (cfg_ready) t = cyc;
      end
      check("hs_seen", 64'(t >= 0), 64'd1);
      if (t < 0) begin
         cfg_valid = 1'b0;
         return;
      end
      if (chain) check("b2b_accept", 64'(t), 64'(last_done + 1));
      budget = 3 * int'(r) + 12;
      while (!got_done) begin
         tick();
         if (!hold) cfg_valid = 1'b0;
         if (acc_rd_en) begin
            check("rd_mode", 64'(act_mode), 64'(m));
            if (exp_rd.size() == 0) extra_rd++;
            else check("rd_addr", 64'(acc_rd_addr), 64'(exp_rd.pop_front()));
         end
         if (prev_rd) begin
            check("cap_sum", act_sum, mem[prev_addr]);
            check("cap_mode", 64'(act_mode), 64'(m));
         end
         prev_rd = acc_rd_en;
         prev_addr = acc_rd_addr;
         if (out_valid) begin
            if (exp_wa.size() == 0) extra_wr++;
            else begin
               check("wr_addr", 64'(out_addr), 64'(exp_wa[0]));
               check("wr_data", out_data, exp_wd[0]);
            end
            if (row == abort_row) begin
               rst = 1'b1;
               #1;
               check("rst_valid", 64'(out_valid), 64'd0);
               check("rst_busy", 64'(busy), 64'd0);
               check("rst_done", 64'(done), 64'd0);
               check("rst_mode", 64'(act_mode), 64'd0);
               check("rst_rd_en", 64'(acc_rd_en), 64'd0);
               tick();
               rst = 1'b0;
               out_ready = 1'b0;
               #1;
               check("rst_rdy", 64'(cfg_ready), 64'd1);
               return;
            end
            if (row == 0 && forced < stall0) begin
               out_ready = 1'b0;
               forced++;
            end else begin
               out_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
            end
            if (out_ready) begin
               if (exp_wa.size() > 0) begin
                  void'(exp_wa.pop_front());
                  void'(exp_wd.pop_front());
               end
               row++;
            end else begin
               stalls++;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         if (done) begin
            got_done = 1'b1;
            last_done = cyc;
            check("done_cyc", 64'(cyc),
                  (legal && r != 0) ? 64'(t + 1 + 3 * int'(r) + stalls) : 64'(t + 1));
            check("err", 64'(err), 64'(!legal));
            check("done_busy", 64'(busy), 64'd1);
            check("done_rdy", 64'(cfg_ready), 64'd0);
            check("rd_left", 64'(exp_rd.size()), 64'd0);
            check("wr_left", 64'(exp_wa.size()), 64'd0);
            check("extra_rd", 64'(extra_rd), 64'd0);
            check("extra_wr", 64'(extra_wr), 64'd0);
         end else if (err) begin
            check("err_no_done", 64'(err), 64'd0);
         end
         if (cyc - t > budget + stalls) break;
      end
      check("done_seen", 64'(got_done), 64'd1);
      if (hold) return;
      cfg_valid = 1'b0;
      tick();
      check("idle_rdy", 64'(cfg_ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_mode", 64'(act_mode), 64'd0);
      check("idle_done", 64'(done), 64'd0);
   endtask

   initial begin
      bit prev_hold;
      bit h;
      logic [2:0] m;
      foreach (mem[i]) mem[i] = {$urandom, $urandom};
      rst = 1'b1; cfg_valid = 1'b0; cfg_mode = '0; cfg_rows = '0;
      cfg_src_base = '0; cfg_dst_base = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_cfg_rdy", 64'(cfg_ready), 64'd0);
      check("rst_busy0", 64'(busy), 64'd0);
      check("rst_valid0", 64'(out_valid), 64'd0);
      check("rst_rd0", 64'(acc_rd_en), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_addr", 64'(out_addr), 64'd0);
      check("rst_sum", act_sum, 64'd0);
      rst = 1'b0;
      #1;
      check("rdy_after_rst", 64'(cfg_ready), 64'd1);

      mem[8'h10] = 64'h0102030405060708;
      mem[8'h11] = 64'h8000FF7F00010203;
      run_job(3'd2, 8'd2, 8'h10, 8'h40, 0, 0, -1, 1'b0, 1'b0);   // identity stub job
      run_job(3'd2, 8'd2, 8'h10, 8'h40, 0, 4, -1, 1'b0, 1'b0);   // 4-cycle backpressure
      run_job(3'd0, 8'd0, 8'h33, 8'h44, 0, 0, -1, 1'b0, 1'b0);   // empty job
      run_job(3'd5, 8'd3, 8'h33, 8'h44, 0, 0, -1, 1'b0, 1'b0);   // illegal mode
      run_job(3'd1, 8'd3, 8'hFE, 8'hFF, 0, 0, -1, 1'b0, 1'b0);   // address wrap
      run_job(3'd3, 8'd4, 8'h20, 8'h30, 0, 0, 1, 1'b0, 1'b0);    // reset during row 1 WR
      run_job(3'd2, 8'd1, 8'h50, 8'h60, 0, 0, -1, 1'b0, 1'b0);
      run_job(3'd0, 8'd2, 8'h70, 8'h80, 0, 0, -1, 1'b1, 1'b0);   // back-to-back pair
      run_job(3'd3, 8'd2, 8'h90, 8'hA0, 0, 0, -1, 1'b0, 1'b1);

      prev_hold = 1'b0;
      for (int j = 0; j < 30; j++) begin
         m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         h = (j != 29) && ($urandom_range(0, 2) == 0);
         run_job(m, 8'($urandom_range(0, 6)), 8'($urandom), 8'($urandom),
                 30, 0, -1, h, prev_hold);
         prev_hold = h;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
